// File: rtl/servo_pkg.sv
// Shared widths and the angle-to-pulse-width conversion used by the
// multi-channel servo PWM generator.
package servo_pkg;

    localparam int CH_IDX_W  = 4;
    localparam int ANGLE_MAX = 180;

    function automatic int clog2_min1(input int unsigned v);
        int r;
        r = $clog2(v);
        return (r < 1) ? 1 : r;
    endfunction

    // Pulse-width register width in bits, ceil(log2(MAX_US+1)).
    function automatic int calc_us_w(input int unsigned max_us);
        return clog2_min1(max_us + 1);
    endfunction

    // Microsecond counter width in bits, ceil(log2(PERIOD_US)).
    function automatic int calc_cnt_w(input int unsigned period_us);
        return clog2_min1(period_us);
    endfunction

    // Prescaler width in bits for a CLK_HZ/1 MHz divider.
    function automatic int calc_pre_w(input int unsigned clk_hz);
        return clog2_min1(clk_hz / 1_000_000);
    endfunction

    // Angles above 180 deg saturate rather than being rejected.
    function automatic int unsigned width(input int unsigned angle,
                                          input int unsigned min_us,
                                          input int unsigned max_us);
        int unsigned a;
        a = (angle > ANGLE_MAX) ? ANGLE_MAX : angle;
        return min_us + (a * (max_us - min_us)) / ANGLE_MAX;
    endfunction

endpackage

// File: rtl/servo_slew_ch.sv
// One servo channel: target/current width registers, per-frame slew step
// and the registered pulse compare against the shared microsecond counter.
module servo_slew_ch
    import servo_pkg::*;
#(
    parameter int              US_W    = 11,
    parameter int              CNT_W   = 15,
    parameter int              STEP_US = 10,
    parameter logic [US_W-1:0] RESET_W = 11'd1500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start_i,
    input  logic [CNT_W-1:0] us_cnt_i,
    input  logic             ch_en_i,
    input  logic             wr_i,
    input  logic [US_W-1:0]  wr_width_i,
    output logic             pwm_o,
    output logic             settled_o
);

    localparam int unsigned STEP_U = STEP_US;

    logic [US_W-1:0] tgt_q, tgt_d;
    logic [US_W-1:0] cur_q, cur_d;
    logic [US_W-1:0] diff;
    logic            seen_q, seen_d;
    logic            pwm_q, pwm_d;

    always_comb begin
        tgt_d  = wr_i ? wr_width_i : tgt_q;
        cur_d  = cur_q;
        seen_d = seen_q & ch_en_i;
        diff   = (tgt_q > cur_q) ? (tgt_q - cur_q) : (cur_q - tgt_q);
        if (frame_start_i) begin
            // A channel must be enabled at the frame boundary to pulse in that frame.
            seen_d = ch_en_i;
            if (!ch_en_i || STEP_U == 0 || 32'(diff) <= STEP_U) begin
                cur_d = tgt_q;
            end else if (tgt_q > cur_q) begin
                cur_d = cur_q + US_W'(STEP_U);
            end else begin
                cur_d = cur_q - US_W'(STEP_U);
            end
        end
        pwm_d = ch_en_i && seen_d && (us_cnt_i < CNT_W'(cur_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q  <= RESET_W;
            cur_q  <= RESET_W;
            seen_q <= 1'b0;
            pwm_q  <= 1'b0;
        end else begin
            tgt_q  <= tgt_d;
            cur_q  <= cur_d;
            seen_q <= seen_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o     = pwm_q;
    assign settled_o = (cur_q == tgt_q);

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel 50 Hz servo PWM generator: shared 1 us timebase, angle write
// port with range check, and one slew-limited channel per servo output.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CLK_HZ      = 100_000_000,
    parameter int PERIOD_US   = 20000,
    parameter int MIN_US      = 1000,
    parameter int MAX_US      = 2000,
    parameter int STEP_US     = 10,
    parameter int RESET_ANGLE = 90
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [CH_IDX_W-1:0] wr_ch,
    input  logic [7:0]          wr_angle,
    input  logic [NUM_CH-1:0]   ch_en,
    output logic [NUM_CH-1:0]   pwm,
    output logic                frame_start,
    output logic [NUM_CH-1:0]   settled,
    output logic                wr_err
);

    localparam int PRE_DIV = CLK_HZ / 1_000_000;
    localparam int PRE_W   = calc_pre_w(CLK_HZ);
    localparam int CNT_W   = calc_cnt_w(PERIOD_US);
    localparam int US_W    = calc_us_w(MAX_US);
    localparam logic [US_W-1:0] RESET_W = US_W'(width(RESET_ANGLE, MIN_US, MAX_US));

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] us_q, us_d;
    logic             pre_wrap;
    logic             ch_ok;
    logic             wr_valid;
    logic             wr_err_q, wr_err_d;
    logic [US_W-1:0]  wr_width;

    always_comb begin
        pre_wrap = (pre_q == PRE_W'(PRE_DIV - 1));
        pre_d    = pre_wrap ? '0 : pre_q + 1'b1;
        us_d     = us_q;
        if (pre_wrap) begin
            us_d = (us_q == CNT_W'(PERIOD_US - 1)) ? '0 : us_q + 1'b1;
        end
    end

    // Counters sit at zero while held in reset; keep the strobe quiet there.
    assign frame_start = clr && (pre_q == '0) && (us_q == '0);

    always_comb begin
        ch_ok    = ({1'b0, wr_ch} < (CH_IDX_W + 1)'(NUM_CH));
        wr_valid = wr_en && ch_ok;
        wr_err_d = wr_en && !ch_ok;
        wr_width = US_W'(width(32'(wr_angle), MIN_US, MAX_US));
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pre_q    <= '0;
            us_q     <= '0;
            wr_err_q <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            us_q     <= us_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign wr_err = wr_err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_slew_ch #(
            .US_W    (US_W),
            .CNT_W   (CNT_W),
            .STEP_US (STEP_US),
            .RESET_W (RESET_W)
        ) u_ch (
            .clk           (clk),
            .rst_n         (clr),
            .frame_start_i (frame_start),
            .us_cnt_i      (us_q),
            .ch_en_i       (ch_en[i]),
            .wr_i          (wr_valid && (wr_ch == CH_IDX_W'(i))),
            .wr_width_i    (wr_width),
            .pwm_o         (pwm[i]),
            .settled_o     (settled[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: two instances (slew-limited and unlimited) share
// one stimulus and are checked each cycle against a frame-level model.
module tb_servo_pwm_multi;

    localparam int NCH    = 4;
    localparam int CLK_HZ = 2_000_000;
    localparam int PRE    = 2;
    localparam int PERIOD = 2100;
    localparam int F      = PRE * PERIOD;
    localparam int MINU   = 1000;
    localparam int MAXU   = 2000;
    localparam int STEP_A = 200;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_ch = 4'd0;
    logic [7:0] wr_angle = 8'd0;
    logic [3:0] ch_en = 4'hF;

    logic [3:0] pwm_a, pwm_b, set_a, set_b;
    logic       fs_a, fs_b, err_a, err_b;

    always #5 clk = ~clk;

    servo_pwm_multi #(
        .NUM_CH(NCH), .CLK_HZ(CLK_HZ), .PERIOD_US(PERIOD), .MIN_US(MINU),
        .MAX_US(MAXU), .STEP_US(STEP_A), .RESET_ANGLE(90)
    ) u_dut_a (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_ch(wr_ch), .wr_angle(wr_angle),
        .ch_en(ch_en), .pwm(pwm_a), .frame_start(fs_a), .settled(set_a), .wr_err(err_a)
    );

    servo_pwm_multi #(
        .NUM_CH(NCH), .CLK_HZ(CLK_HZ), .PERIOD_US(PERIOD), .MIN_US(MINU),
        .MAX_US(MAXU), .STEP_US(0), .RESET_ANGLE(90)
    ) u_dut_b (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_ch(wr_ch), .wr_angle(wr_angle),
        .ch_en(ch_en), .pwm(pwm_b), .frame_start(fs_b), .settled(set_b), .wr_err(err_b)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int tgt [2][NCH];
    int cur [2][NCH];
    bit ok [2][NCH];
    bit exp_pwm [2][NCH];
    bit exp_err;
    int step_of [2] = '{STEP_A, 0};

    int hi_cnt [2][NCH];
    int last_w [2][NCH];
    int last_fs = -1;
    int fs_period = 0;
    int err_cnt = 0;

    logic [3:0] pw_s [2];
    logic [3:0] st_s [2];
    logic       fs_s [2];
    logic       er_s [2];

    function automatic int w_of(input int a);
        int c;
        c = (a > 180) ? 180 : a;
        return MINU + (c * (MAXU - MINU)) / 180;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        pw_s[0] = pwm_a; pw_s[1] = pwm_b;
        st_s[0] = set_a; st_s[1] = set_b;
        fs_s[0] = fs_a;  fs_s[1] = fs_b;
        er_s[0] = err_a; er_s[1] = err_b;
        if (!clr) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("rst_pwm%0d", d), int'(pw_s[d]), 0);
                chk($sformatf("rst_fs%0d", d), int'(fs_s[d]), 0);
                chk($sformatf("rst_err%0d", d), int'(er_s[d]), 0);
                chk($sformatf("rst_settled%0d", d), int'(st_s[d]), 15);
                for (int i = 0; i < NCH; i++) begin
                    tgt[d][i] = 1500;
                    cur[d][i] = 1500;
                    ok[d][i] = 1'b0;
                    exp_pwm[d][i] = 1'b0;
                    hi_cnt[d][i] = 0;
                end
            end
            exp_err = 1'b0;
            last_fs = -1;
            fs_period = 0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("frame_start%0d", d), int'(fs_s[d]), int'(cyc % F == 0));
                chk($sformatf("wr_err%0d", d), int'(er_s[d]), int'(exp_err));
                for (int i = 0; i < NCH; i++) begin
                    chk($sformatf("pwm%0d[%0d]", d, i), int'(pw_s[d][i]), int'(exp_pwm[d][i]));
                    chk($sformatf("settled%0d[%0d]", d, i), int'(st_s[d][i]),
                        int'(cur[d][i] == tgt[d][i]));
                end
            end

            if (fs_a) begin
                if (last_fs >= 0) fs_period = cyc - last_fs;
                last_fs = cyc;
            end
            if (err_a) err_cnt++;
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < NCH; i++) begin
                    if (cyc % F == 0) begin
                        last_w[d][i] = hi_cnt[d][i] + int'(pw_s[d][i]);
                        hi_cnt[d][i] = 0;
                    end else begin
                        hi_cnt[d][i] += int'(pw_s[d][i]);
                    end
                end
            end

            // Width in force for a frame is decided at its first cycle.
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < NCH; i++) begin
                    if (cyc % F == 0) begin
                        if (!ch_en[i] || step_of[d] == 0 || iabs(tgt[d][i] - cur[d][i]) <= step_of[d])
                            cur[d][i] = tgt[d][i];
                        else if (tgt[d][i] > cur[d][i])
                            cur[d][i] = cur[d][i] + step_of[d];
                        else
                            cur[d][i] = cur[d][i] - step_of[d];
                        ok[d][i] = ch_en[i];
                    end else begin
                        ok[d][i] = ok[d][i] && ch_en[i];
                    end
                    exp_pwm[d][i] = ch_en[i] && ok[d][i] && ((cyc % F) < PRE * cur[d][i]);
                end
            end
            exp_err = 1'b0;
            if (wr_en) begin
                if (int'(wr_ch) < NCH) begin
                    for (int d = 0; d < 2; d++) tgt[d][int'(wr_ch)] = w_of(int'(wr_angle));
                end else begin
                    exp_err = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic goto_pos(input int p);
        int n;
        n = 0;
        do begin
            tick(1);
            n++;
        end while ((cyc % F) != p && n < 2 * F);
        if ((cyc % F) != p) chk("goto_pos_timeout", cyc % F, p);
    endtask

    task automatic wr(input int ch, input int ang);
        wr_en = 1'b1;
        wr_ch = 4'(ch);
        wr_angle = 8'(ang);
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        clr = 1'b1;
        cyc = 0;
    endtask

    task automatic chk_w(input int d, input int i, input int exp);
        chk($sformatf("width%0d[%0d]", d, i), last_w[d][i], exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        release_rst();

        goto_pos(1);
        goto_pos(1);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NCH; i++) chk_w(d, i, 3000);
        chk("fs_period", fs_period, 4200);

        goto_pos(1000);
        wr(1, 180);
        wr(3, 1);
        goto_pos(1);
        chk_w(0, 1, 3000);
        chk_w(1, 1, 3000);
        goto_pos(1);
        chk_w(0, 1, 3400);
        chk_w(1, 1, 4000);
        chk_w(0, 3, 2600);
        chk_w(1, 3, 2010);
        chk("settled_a_ramp", int'(set_a), 4'b0101);
        chk("settled_b_jump", int'(set_b), 4'b1111);
        goto_pos(1);
        chk_w(0, 1, 3800);
        chk_w(0, 3, 2200);
        goto_pos(1);
        chk_w(0, 1, 4000);
        chk_w(0, 3, 2010);
        chk_w(0, 0, 3000);
        chk("settled_a_done", int'(set_a), 4'b1111);

        goto_pos(200);
        wr(7, 0);
        tick(3);
        chk("wr_err_count", err_cnt, 1);
        goto_pos(0);
        wr(0, 200);
        tick(2);
        chk("wr_err_count_clamp", err_cnt, 1);
        goto_pos(1);
        chk_w(0, 0, 3000);
        chk_w(1, 0, 3000);
        goto_pos(1);
        chk_w(0, 0, 3400);
        chk_w(1, 0, 4000);

        goto_pos(500);
        ch_en = 4'b1011;
        wr(2, 0);
        goto_pos(1);
        goto_pos(1000);
        ch_en = 4'b1111;
        goto_pos(1);
        chk_w(0, 2, 0);
        chk_w(1, 2, 0);
        goto_pos(1);
        chk_w(0, 2, 2000);
        chk_w(1, 2, 2000);

        goto_pos(100);
        @(posedge clk);
        #2;
        chk("pwm_before_rst", int'(pwm_a), 4'hF);
        #1;
        clr = 1'b0;
        #1;
        chk("pwm_async_rst_a", int'(pwm_a), 0);
        chk("pwm_async_rst_b", int'(pwm_b), 0);
        repeat (3) @(posedge clk);
        release_rst();
        goto_pos(1);
        goto_pos(1);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < NCH; i++) chk_w(d, i, 3000);
        chk("fs_period_after_rst", fs_period, 4200);

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
